// File: rtl/fht_pkg.sv
// Shared types and elaboration-time helpers for the FHT address controller.
`default_nettype none

package fht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Ceiling log2; for the power-of-two transform lengths this is exact.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int a_bit(input int n);
    return log2(n);
  endfunction

  function automatic int pipe(input int rd_lat, input int but_lat);
    return rd_lat + but_lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fht_addr_gen.sv
// Combinational butterfly operand and twiddle-ROM address generator for stage s, butterfly b.
`default_nettype none

module fht_addr_gen
  import fht_pkg::*;
#(
  parameter int A_BIT = 8,
  parameter int SW    = 3
) (
  input  logic [SW-1:0]    stage,
  input  logic [A_BIT-2:0] bf,
  output logic [A_BIT-1:0] a0,
  output logic [A_BIT-1:0] a1,
  output logic [A_BIT-1:0] a2,
  output logic [A_BIT-2:0] rom
);

  logic [A_BIT-2:0] mask;
  logic [A_BIT-2:0] k;
  logic [A_BIT-2:0] kn;
  logic [A_BIT-2:0] hi;
  logic [A_BIT-1:0] base;
  logic [A_BIT-1:0] h;

  // mask = H-1; the bits above it select the group, so base = g*2H is hi shifted left once.
  always_comb begin
    mask = ~({(A_BIT-1){1'b1}} << stage);
    k    = bf & mask;
    kn   = (-k) & mask;
    hi   = bf & ~mask;
    base = {hi, 1'b0};
    h    = {1'b0, mask} + A_BIT'(1);
    a0   = base + {1'b0, k};
    a1   = base + h + {1'b0, k};
    a2   = base + h + {1'b0, kn};
    rom  = k << (SW'(A_BIT - 1) - stage);
  end

endmodule

`default_nettype wire

// File: rtl/fht_ctrl.sv
// FHT stage sequencer: issues one butterfly per cycle, drains the pipeline between stages,
// and replays read addresses as write addresses PIPE cycles later into the opposite bank.
`default_nettype none

module fht_ctrl
  import fht_pkg::*;
#(
  parameter int N       = 256,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 2
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  output logic                       oRD_EN,
  output logic [a_bit(N)-1:0]        oRD_ADDR_0,
  output logic [a_bit(N)-1:0]        oRD_ADDR_1,
  output logic [a_bit(N)-1:0]        oRD_ADDR_2,
  output logic [a_bit(N)-2:0]        oROM_ADDR,
  output logic                       oWR_EN,
  output logic [a_bit(N)-1:0]        oWR_ADDR_0,
  output logic [a_bit(N)-1:0]        oWR_ADDR_1,
  output logic                       oBANK,
  output logic [log2(log2(N))-1:0]   oSTAGE,
  output logic                       oBUSY,
  output logic                       oDONE
);

  localparam int S     = log2(N);
  localparam int A_BIT = a_bit(N);
  localparam int PIPE  = pipe(RD_LAT, BUT_LAT);
  localparam int SW    = log2(S);
  localparam int FW    = log2(PIPE + 1);

  localparam logic [A_BIT-2:0] LAST_BF    = '1;
  localparam logic [SW-1:0]    LAST_STAGE = SW'(S - 1);
  localparam logic [FW-1:0]    LAST_FLUSH = FW'(PIPE - 1);

  state_t           state;
  logic [A_BIT-2:0] bf;
  logic [SW-1:0]    stage;
  logic [FW-1:0]    fcnt;
  logic             bank;
  logic             busy;
  logic             done;
  logic             rd_en;

  logic [A_BIT-1:0] a0, a1, a2;
  logic [A_BIT-2:0] rom;

  logic [PIPE-1:0]  wen_d;
  logic [A_BIT-1:0] wa0_d [PIPE];
  logic [A_BIT-1:0] wa1_d [PIPE];

  fht_addr_gen #(
    .A_BIT (A_BIT),
    .SW    (SW)
  ) u_addr_gen (
    .stage (stage),
    .bf    (bf),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .rom   (rom)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= ST_IDLE;
      bf    <= '0;
      stage <= '0;
      fcnt  <= '0;
      bank  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iSTART) begin
            state <= ST_RUN;
            bf    <= '0;
            stage <= '0;
            bank  <= 1'b0;
            busy  <= 1'b1;
            rd_en <= 1'b1;
          end
        end
        ST_RUN: begin
          bf <= bf + (A_BIT-1)'(1);
          if (bf == LAST_BF) begin
            state <= ST_FLUSH;
            fcnt  <= '0;
            rd_en <= 1'b0;
          end
        end
        ST_FLUSH: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == LAST_FLUSH) begin
            if (stage == LAST_STAGE) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              stage <= stage + SW'(1);
              bank  <= ~bank;
              rd_en <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Reset clears the whole delay line, so in-flight writes never emerge afterwards.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wen_d <= '0;
      for (int i = 0; i < PIPE; i++) begin
        wa0_d[i] <= '0;
        wa1_d[i] <= '0;
      end
    end else begin
      wen_d[0] <= rd_en;
      wa0_d[0] <= rd_en ? a0 : '0;
      wa1_d[0] <= rd_en ? a1 : '0;
      for (int i = 1; i < PIPE; i++) begin
        wen_d[i] <= wen_d[i-1];
        wa0_d[i] <= wa0_d[i-1];
        wa1_d[i] <= wa1_d[i-1];
      end
    end
  end

  assign oRD_EN     = rd_en;
  assign oRD_ADDR_0 = rd_en ? a0 : '0;
  assign oRD_ADDR_1 = rd_en ? a1 : '0;
  assign oRD_ADDR_2 = rd_en ? a2 : '0;
  assign oROM_ADDR  = rd_en ? rom : '0;
  assign oWR_EN     = wen_d[PIPE-1];
  assign oWR_ADDR_0 = wa0_d[PIPE-1];
  assign oWR_ADDR_1 = wa1_d[PIPE-1];
  assign oBANK      = bank;
  assign oSTAGE     = stage;
  assign oBUSY      = busy;
  assign oDONE      = done;

endmodule

`default_nettype wire

// File: tb/tb_fht_ctrl.sv
// Scoreboard bench for fht_ctrl at N=16, RD_LAT=1, BUT_LAT=2.
`default_nettype none

module tb_fht_ctrl;

  logic       iCLK = 1'b0;
  logic       iRESET;
  logic       iSTART;
  logic       oRD_EN;
  logic [3:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2;
  logic [2:0] oROM_ADDR;
  logic       oWR_EN;
  logic [3:0] oWR_ADDR_0, oWR_ADDR_1;
  logic       oBANK;
  logic [1:0] oSTAGE;
  logic       oBUSY;
  logic       oDONE;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_rd [$];
  logic [63:0] exp_wr [$];
  int          rd_cyc [$];
  int          cyc  = 0;
  int          rd_n = 0;
  int          wr_n = 0;
  logic [15:0] cov  = '0;

  fht_ctrl #(
    .N       (16),
    .RD_LAT  (1),
    .BUT_LAT (2)
  ) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iSTART     (iSTART),
    .oRD_EN     (oRD_EN),
    .oRD_ADDR_0 (oRD_ADDR_0),
    .oRD_ADDR_1 (oRD_ADDR_1),
    .oRD_ADDR_2 (oRD_ADDR_2),
    .oROM_ADDR  (oROM_ADDR),
    .oWR_EN     (oWR_EN),
    .oWR_ADDR_0 (oWR_ADDR_0),
    .oWR_ADDR_1 (oWR_ADDR_1),
    .oBANK      (oBANK),
    .oSTAGE     (oSTAGE),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference transform: reads in stage/butterfly order, writes mirror the A0/A1 pairs.
  task automatic push_transform();
    int h, g, k, base, a0, a1, a2, rom;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        h    = 1 << s;
        g    = b >> s;
        k    = b % h;
        base = g * 2 * h;
        a0   = base + k;
        a1   = base + h + k;
        a2   = base + h + ((h - k) % h);
        rom  = k << (3 - s);
        exp_rd.push_back(64'((a0 << 14) | (a1 << 10) | (a2 << 6) | (rom << 3) | (s << 1) | (s % 2)));
        exp_wr.push_back(64'((a0 << 4) | a1));
      end
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge iCLK);
      cyc++;
      if (iRESET) begin
        exp_rd.delete();
        exp_wr.delete();
        rd_cyc.delete();
        cov  = '0;
        wr_n = 0;
        rd_n = 0;
      end else begin
        if (oRD_EN) begin
          check_val("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
          if (exp_rd.size() != 0) begin
            e = exp_rd.pop_front();
            check_val($sformatf("rd[%0d]", rd_n % 32),
                      {oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR, oSTAGE, oBANK}, e);
          end
          if (rd_n % 32 == 0)
            check_val("s0_b0", {oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR},
                      {4'd0, 4'd1, 4'd1, 3'd0});
          if (rd_n % 32 == 21)
            check_val("s2_b5", {oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR},
                      {4'd9, 4'd13, 4'd15, 3'd2});
          rd_cyc.push_back(cyc);
          rd_n++;
        end
        if (oWR_EN) begin
          check_val("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check_val("wr_addr", {oWR_ADDR_0, oWR_ADDR_1}, e);
          end
          if (rd_cyc.size() != 0) check_val("wr_delay", 64'(cyc - rd_cyc.pop_front()), 64'd3);
          cov  = cov | (16'd1 << oWR_ADDR_0) | (16'd1 << oWR_ADDR_1);
          wr_n++;
          if (wr_n == 8) begin
            check_val("stage_cover", cov, 64'hFFFF);
            cov  = '0;
            wr_n = 0;
          end
        end
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after oDONE.
  task automatic run_transform(input bit hold);
    int lat;
    push_transform();
    iSTART = 1'b1;
    @(negedge iCLK);
    lat = 1;
    if (!hold) iSTART = 1'b0;
    check_val("busy_rise", oBUSY, 1);
    while (!oDONE && lat < 200) begin
      @(negedge iCLK);
      lat++;
    end
    check_val("done_latency", lat, 45);
    @(negedge iCLK);
    check_val("done_pulse", {oDONE, oBUSY}, 2'b00);
    check_val("rd_drained", exp_rd.size(), 0);
    check_val("wr_drained", exp_wr.size(), 0);
  endtask

  initial begin
    int n, wr_seen, busy_seen;
    iRESET = 1'b1;
    iSTART = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge iCLK);
    check_val("reset_outs", {oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR, oWR_EN,
                             oWR_ADDR_0, oWR_ADDR_1, oBANK, oSTAGE, oBUSY, oDONE}, 0);
    iRESET = 1'b0;
    @(negedge iCLK);

    run_transform(1'b0);
    repeat (2) @(negedge iCLK);

    // Abort in stage 1 while butterflies are in flight.
    push_transform();
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    n = 0;
    while (!(oRD_EN && oSTAGE == 2'd1) && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    check_val("reach_stage1", {oRD_EN, oSTAGE}, 3'b101);
    #3 iRESET = 1'b1;
    #1 check_val("async_reset_outs", {oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR,
                                      oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oBANK, oSTAGE, oBUSY,
                                      oDONE}, 0);
    repeat (2) @(negedge iCLK);
    iRESET  = 1'b0;
    wr_seen = 0;
    repeat (12) begin
      @(negedge iCLK);
      if (oWR_EN || oBUSY) wr_seen++;
    end
    check_val("quiet_after_reset", wr_seen, 0);

    run_transform(1'b0);
    @(negedge iCLK);

    // Start held high: back-to-back transforms separated by one IDLE cycle.
    run_transform(1'b1);
    run_transform(1'b1);
    iSTART    = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      @(negedge iCLK);
      if (oBUSY) busy_seen++;
    end
    check_val("no_third_run", busy_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fht_ctrl.md
FHT_CTRL -- requirements
Module: fht_ctrl

Interface
REQ-001 Parameter N, default 256: transform length, power of two, 16..4096.
REQ-002 Parameter RD_LAT, default 1: RAM read latency in cycles.
REQ-003 Parameter BUT_LAT, default 2: butterfly latency in cycles, from operands valid to outputs valid.
REQ-004 Derived localparams: S = log2(N) stages; A_BIT = log2(N) address width; PIPE = RD_LAT + BUT_LAT.
REQ-005 iCLK  in  1  single clock, all logic on rising edge.
REQ-006 iRESET  in  1  asynchronous, active-high reset.
REQ-007 iSTART  in  1  start request; sampled in IDLE only.
REQ-008 oRD_EN  out  1  read strobe for the three operand ports.
REQ-009 oRD_ADDR_0 / oRD_ADDR_1 / oRD_ADDR_2  out  A_BIT each  butterfly operand addresses x0/x1/x2.
REQ-010 oROM_ADDR  out  A_BIT-1  sin/cos ROM address.
REQ-011 oWR_EN  out  1  write strobe for butterfly outputs.
REQ-012 oWR_ADDR_0 / oWR_ADDR_1  out  A_BIT each  destinations of oY_0 / oY_1.
REQ-013 oBANK  out  1  ping-pong select; read bank = oBANK, write bank = ~oBANK.
REQ-014 oSTAGE  out  log2(S) bits  current stage index.
REQ-015 oBUSY  out  1  high in every state except IDLE.
REQ-016 oDONE  out  1  one-cycle pulse when the transform completes.

Function
REQ-017 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-018 FSM transitions:
- IDLE -> RUN on iSTART=1.
- RUN -> FLUSH after the last butterfly of a stage issues.
- FLUSH -> RUN after PIPE cycles, stage incremented, if the stage was not the last.
- FLUSH -> DONE after PIPE cycles if the stage was S-1.
- DONE -> IDLE unconditionally.
REQ-019 RUN issues one butterfly per cycle, index b = 0..N/2-1, with oRD_EN=1; oRD_EN=0 in all other states.
REQ-020 Address generation for stage s, b:
- H = 2^s, g = b>>s, k = b & (H-1), base = g*2H.
- A0 = base+k.
- A1 = base+H+k.
- A2 = base+H+((H-k) mod H), so A2 = A1 when k = 0.
REQ-021 oROM_ADDR = k << (S-1-s).
REQ-022 oWR_EN and oWR_ADDR_0/1 (= A0/A1) are the read-side values delayed exactly PIPE cycles through a shift pipeline.
REQ-023 Write pulses continue into FLUSH; no write pulse is issued after FLUSH ends.
REQ-024 oBANK toggles on the FLUSH->RUN transition; oBANK = 0 at the start of every transform.
REQ-025 Total latency from iSTART accepted to oDONE = S*(N/2+PIPE)+1 cycles.
REQ-026 iSTART while oBUSY=1 is ignored; no queuing.
REQ-027 oDONE is asserted in DONE only; a new iSTART is accepted the cycle after DONE.

Reset
REQ-028 iRESET=1 forces, asynchronously:
- state IDLE;
- b, stage, oBANK and all delay pipelines to 0;
- every output to 0.
REQ-029 Reset mid-transform discards in-flight writes; oWR_EN=0 from reset assertion onward, with no trailing pulses.

Structure
REQ-030 Shared package fht_pkg holds the FSM state enum, the A_BIT/PIPE derivation functions and the log2 function.
REQ-031 Single sub-module fht_addr_gen (combinational A0/A1/A2/ROM address from s, b); the FSM, counters and delay line stay in fht_ctrl.

Verification (N=16, RD_LAT=1, BUT_LAT=2)
REQ-032 iSTART=1 for one cycle -> oBUSY rises the next cycle; oDONE pulses exactly 4*(8+3)+1 = 45 cycles after the start edge.
REQ-033 Stage 0, b=0 -> A0=0, A1=1, A2=1, oROM_ADDR=0.
REQ-034 Stage 2, b=5 -> A0=9, A1=13, A2=15, oROM_ADDR=2.
REQ-035 Each butterfly's oWR_EN/oWR_ADDR_0/1 appears exactly 3 cycles after its oRD_EN; per stage, 8 write pulses are counted and the A0/A1 set covers 0..15 once.
REQ-036 iRESET asserted in stage 1 RUN -> all outputs 0 immediately and no oWR_EN afterward; a following iSTART runs a full transform starting with oBANK=0.
REQ-037 iSTART held high through a transform -> exactly one transform per IDLE entry; a second transform starts the cycle after oDONE.
